// File: rtl/lightsout_grid.sv
// Purpose : N x N Lights-Out engine. Scans a shared LED/button matrix, debounces each cell, runs IDLE/SCRAMBLE/PLAY.
// Latency : a press toggles the board 2 clocks after the debounce shift register sees its rising pattern.
// Backpressure: none; buttons are sampled on every column visit, and presses are dropped while scrambling.
// Ports   : clk, rst_n (sync, active low); btn_row (row returns for the strobed column);
//           led_row (active-low LED drive); col (one-hot column strobe);
//           done (solved / IDLE); busy (SCRAMBLE); moves (saturating press count).
module lightsout_grid #(
    parameter int          N                = 3,
    parameter int          DEBOUNCE_LEN     = 16,
    parameter logic [15:0] SEED             = 16'hBEEF,
    parameter bit          TORUS            = 1'b0,
    parameter int          SCRAMBLE_PRESSES = 12,
    parameter int          COUNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       btn_row,
    output logic [N-1:0]       led_row,
    output logic [N-1:0]       col,
    output logic               done,
    output logic               busy,
    output logic [COUNT_W-1:0] moves
);
    localparam int NN     = N * N;
    localparam int CIDX_W = $clog2(N);
    localparam int IDX_W  = $clog2(NN);
    localparam int SCNT_W = $clog2(SCRAMBLE_PRESSES + 1);
    // Oldest sample low, every newer sample high: a clean rising press.
    localparam logic [DEBOUNCE_LEN-1:0] PRESS_PAT = {1'b0, {(DEBOUNCE_LEN-1){1'b1}}};
    localparam logic [SCNT_W-1:0]       SCNT_LOAD = SCNT_W'(SCRAMBLE_PRESSES);

    typedef enum logic [1:0] {S_IDLE, S_SCRAMBLE, S_PLAY} state_t;

    state_t                  r_state;
    logic [CIDX_W-1:0]       r_col_idx;
    logic [NN-1:0]           r_board;
    logic [DEBOUNCE_LEN-1:0] r_deb [NN];
    logic [N-1:0]            r_evt_row;
    logic [CIDX_W-1:0]       r_evt_col;
    logic [15:0]             r_lfsr;
    logic                    r_done;
    logic                    r_busy;
    logic [COUNT_W-1:0]      r_moves;
    logic [SCNT_W-1:0]       r_scr_cnt;

    logic [N-1:0]            w_hit;
    logic [NN-1:0]           w_evt_mask;
    logic [NN-1:0]           w_play_board;
    logic [NN-1:0]           w_scr_mask;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_idx_ok;

    // Cross-shaped toggle mask. Each neighbour is XORed in, so on a 2-wide
    // torus the two coincident neighbours cancel each other.
    function automatic logic [NN-1:0] f_mask(input int r, input int c);
        logic [NN-1:0] m;
        int up, dn, lf, rt;
        up = (r > 0)     ? (r - 1) * N + c : (TORUS ? (N - 1) * N + c : -1);
        dn = (r < N - 1) ? (r + 1) * N + c : (TORUS ? c : -1);
        lf = (c > 0)     ? r * N + c - 1   : (TORUS ? r * N + N - 1 : -1);
        rt = (c < N - 1) ? r * N + c + 1   : (TORUS ? r * N : -1);
        for (int i = 0; i < NN; i++) begin
            m[i] = (i == r * N + c) ^ (i == up) ^ (i == dn) ^ (i == lf) ^ (i == rt);
        end
        return m;
    endfunction

    // Column strobe, LED drive and press detection for the current column.
    always_comb begin
        col     = '0;
        led_row = '1;
        w_hit   = '0;
        for (int c = 0; c < N; c++) begin
            if (r_col_idx == CIDX_W'(c)) begin
                col[c] = 1'b1;
                for (int r = 0; r < N; r++) begin
                    led_row[r] = ~r_board[r * N + c];
                    w_hit[r]   = ({r_deb[r * N + c][DEBOUNCE_LEN-2:0], btn_row[r]} == PRESS_PAT);
                end
            end
        end
    end

    // Several rows may fire in one column on the same clock; their masks combine.
    always_comb begin
        w_evt_mask = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r_evt_row[r] && (r_evt_col == CIDX_W'(c))) begin
                    w_evt_mask = w_evt_mask ^ f_mask(r, c);
                end
            end
        end
    end

    assign w_play_board = r_board ^ w_evt_mask;
    assign w_idx        = r_lfsr[IDX_W-1:0];
    // Extra bit so the compare works when N*N is an exact power of two.
    assign w_idx_ok     = ({1'b0, w_idx} < (IDX_W+1)'(NN));

    always_comb begin
        w_scr_mask = '0;
        for (int i = 0; i < NN; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_scr_mask = f_mask(i / N, i % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_col_idx <= '0;
            r_board   <= '0;
            r_evt_row <= '0;
            r_evt_col <= '0;
            r_lfsr    <= SEED;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_moves   <= '0;
            r_scr_cnt <= '0;
            for (int i = 0; i < NN; i++) begin
                r_deb[i] <= '0;
            end
        end else begin
            r_col_idx <= (r_col_idx == CIDX_W'(N - 1)) ? '0 : r_col_idx + 1'b1;
            for (int c = 0; c < N; c++) begin
                if (r_col_idx == CIDX_W'(c)) begin
                    for (int r = 0; r < N; r++) begin
                        r_deb[r * N + c] <= {r_deb[r * N + c][DEBOUNCE_LEN-2:0], btn_row[r]};
                    end
                end
            end
            r_evt_row <= w_hit;
            r_evt_col <= r_col_idx;
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

            case (r_state)
                S_IDLE: begin
                    // The starting press only launches a new puzzle; it never toggles.
                    if (|r_evt_row) begin
                        r_state   <= S_SCRAMBLE;
                        r_scr_cnt <= SCNT_LOAD;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SCRAMBLE: begin
                    if (r_scr_cnt != '0) begin
                        if (w_idx_ok) begin
                            r_board   <= r_board ^ w_scr_mask;
                            r_scr_cnt <= r_scr_cnt - 1'b1;
                        end
                    end else if (r_board != '0) begin
                        r_state <= S_PLAY;
                        r_busy  <= 1'b0;
                        r_moves <= '0;
                    end else begin
                        // Random presses cancelled out; scramble another round.
                        r_scr_cnt <= SCNT_LOAD;
                    end
                end
                S_PLAY: begin
                    if (|r_evt_row) begin
                        r_board <= w_play_board;
                        if (r_moves != {COUNT_W{1'b1}}) begin
                            r_moves <= r_moves + 1'b1;
                        end
                        if (w_play_board == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done  = r_done;
    assign busy  = r_busy;
    assign moves = r_moves;

endmodule

// File: tb/tb_lightsout_grid.sv
// Purpose : self-checking bench for lightsout_grid (3x3; one flat-edge instance with a 2-bit counter, one torus instance).
// Latency : expected board/moves/done/busy are queued per action and compared once the board has been scanned back.
// Backpressure: none; buttons are driven per column visit from the bench.
module tb_lightsout_grid;
    localparam int          N    = 3;
    localparam logic [15:0] SEED = 16'hBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [N-1:0] btn_a, btn_b, led_a, led_b, col_a, col_b;
    logic         done_a, busy_a, done_b, busy_b;
    logic [1:0]   moves_a;
    logic [7:0]   moves_b;

    lightsout_grid #(.N(N), .DEBOUNCE_LEN(16), .SEED(SEED), .TORUS(1'b0),
                     .SCRAMBLE_PRESSES(12), .COUNT_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .btn_row(btn_a), .led_row(led_a), .col(col_a),
        .done(done_a), .busy(busy_a), .moves(moves_a));

    lightsout_grid #(.N(N), .DEBOUNCE_LEN(16), .SEED(SEED), .TORUS(1'b1),
                     .SCRAMBLE_PRESSES(12), .COUNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .btn_row(btn_b), .led_row(led_b), .col(col_b),
        .done(done_b), .busy(busy_b), .moves(moves_b));

    typedef struct {
        logic [8:0] board;
        int         moves;
        bit         done;
        bit         busy;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [15:0] m_lfsr;
    logic [8:0] m_board [2];
    int         m_moves [2];
    bit         m_play  [2];
    int         p_inst, p_r, p_c, p_visits;
    bit         p_on;

    // Reference LFSR, free-running from reset like the engine's.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] f_mask(input int idx, input bit tor);
        logic [8:0] m;
        int r, c, rr, cc;
        int dr [5];
        int dc [5];
        dr = '{0, -1, 1, 0, 0};
        dc = '{0, 0, 0, -1, 1};
        r = idx / N;
        c = idx % N;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            rr = r + dr[k];
            cc = c + dc[k];
            if (tor) begin
                rr = (rr + N) % N;
                cc = (cc + N) % N;
                m[rr * N + cc] = ~m[rr * N + cc];
            end else if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                m[rr * N + cc] = ~m[rr * N + cc];
            end
        end
        return m;
    endfunction

    function automatic int dut_busy(input int inst);
        return (inst == 1) ? int'(busy_b) : int'(busy_a);
    endfunction

    task automatic drive();
        btn_a = '0;
        btn_b = '0;
        if (p_on && col_a[p_c]) begin
            if (p_inst == 1) btn_b[p_r] = 1'b1;
            else             btn_a[p_r] = 1'b1;
            p_visits++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
    endtask

    task automatic push_exp(input int inst);
        exp_t e;
        e.board = m_board[inst];
        e.moves = m_moves[inst];
        e.done  = !m_play[inst];
        e.busy  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic read_board(input int inst, output logic [8:0] b);
        p_on = 1'b0;
        b    = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (col_a[c]) begin
                    for (int r = 0; r < N; r++) begin
                        b[r * N + c] = ~((inst == 1) ? led_b[r] : led_a[r]);
                    end
                end
            end
        end
    endtask

    task automatic observe(input string tag, input int inst);
        logic [8:0] b;
        exp_t       e;
        read_board(inst, b);
        chk({tag, "_queue"}, exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_board"}, int'(b), int'(e.board));
        chk({tag, "_moves"}, (inst == 1) ? int'(moves_b) : int'(moves_a), e.moves);
        chk({tag, "_done"},  (inst == 1) ? int'(done_b)  : int'(done_a),  int'(e.done));
        chk({tag, "_busy"},  dut_busy(inst), int'(e.busy));
    endtask

    // Press a cell from IDLE, then follow the scramble with the reference LFSR.
    task automatic start_scramble(input int inst, input int r, input int c);
        bit         seen, fin;
        logic [8:0] bd;
        int         cnt, guard, idx, bsy;
        p_inst = inst; p_r = r; p_c = c; p_on = 1'b1; p_visits = 0; seen = 1'b0;
        for (int k = 0; k < 20 * N && !seen; k++) begin
            @(negedge clk);
            if (dut_busy(inst) == 1) seen = 1'b1;
            else                     drive();
        end
        p_on = 1'b0;
        drive();
        chk("scr_visits", seen ? p_visits : -1, 15);
        if (!seen) return;
        bd = m_board[inst]; cnt = 12; fin = 1'b0; guard = 0; bsy = 0;
        while (!fin && guard < 1000) begin
            bsy = dut_busy(inst);
            if (cnt != 0) begin
                idx = int'(m_lfsr[3:0]);
                if (idx < N * N) begin
                    bd ^= f_mask(idx, inst == 1);
                    cnt--;
                end
            end else if (bd != '0) begin
                fin = 1'b1;
            end else begin
                cnt = 12;
            end
            tick();
            guard++;
        end
        chk("scr_busy_last", bsy, 1);
        m_board[inst] = bd;
        m_moves[inst] = 0;
        m_play[inst]  = 1'b1;
        push_exp(inst);
        observe("scramble", inst);
    endtask

    task automatic press_play(input int inst, input int r, input int c, input string tag);
        if (!m_play[inst]) return;
        p_inst = inst; p_r = r; p_c = c; p_on = 1'b1;
        for (int k = 0; k < 16 * N; k++) tick();
        p_on = 1'b0;
        for (int k = 0; k < 2 * N; k++) tick();
        m_board[inst] ^= f_mask(r * N + c, inst == 1);
        if (m_moves[inst] < ((inst == 1) ? 255 : 3)) m_moves[inst]++;
        if (m_board[inst] == '0) m_play[inst] = 1'b0;
        push_exp(inst);
        observe(tag, inst);
    endtask

    initial begin
        logic [8:0] acc;
        int         sol, pick;
        rst_n = 1'b0; btn_a = '0; btn_b = '0; p_on = 1'b0;
        p_inst = 0; p_r = 0; p_c = 0; p_visits = 0;
        for (int i = 0; i < 2; i++) begin
            m_board[i] = '0; m_moves[i] = 0; m_play[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col", int'(col_a), 1);
        chk("rst_led", int'(led_a), 7);
        chk("rst_done", int'(done_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_moves", int'(moves_a), 0);
        rst_n = 1'b1;
        tick(); chk("scan_1", int'(col_a), 2);
        tick(); chk("scan_2", int'(col_a), 4);
        tick(); chk("scan_3", int'(col_a), 1);

        // Short press: 10 visits is too few to register.
        p_inst = 0; p_r = 0; p_c = 0; p_on = 1'b1;
        for (int k = 0; k < 10 * N; k++) tick();
        p_on = 1'b0;
        for (int k = 0; k < 3 * N; k++) tick();
        chk("bounce_done", int'(done_a), 1);
        chk("bounce_busy", int'(busy_a), 0);

        start_scramble(0, 0, 0);
        press_play(0, 1, 1, "tog11");
        press_play(0, 0, 0, "tog00");

        // Solve by searching all press subsets against the model board.
        sol = -1;
        for (int s = 0; s < 512 && sol < 0; s++) begin
            acc = '0;
            for (int i = 0; i < 9; i++) if (s[i]) acc ^= f_mask(i, 1'b0);
            if (acc == m_board[0]) sol = s;
        end
        chk("solve_found", (sol >= 0) ? 1 : 0, 1);
        if (sol >= 0) begin
            for (int i = 0; i < 9; i++) if (sol[i]) press_play(0, i / N, i % N, "solve");
        end
        repeat (10) tick();
        push_exp(0);
        observe("held", 0);

        // Saturation: toggle one cell back and forth without reaching a solved board.
        start_scramble(0, 2, 2);
        pick = 0;
        for (int j = 8; j >= 0; j--) if (f_mask(j, 1'b0) != m_board[0]) pick = j;
        for (int k = 0; k < 6; k++) press_play(0, pick / N, pick % N, "sat");
        chk("sat_moves", int'(moves_a), 3);

        start_scramble(1, 1, 1);
        press_play(1, 0, 0, "torus00");

        // Reset in the middle of a scramble.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_board[i] = '0; m_moves[i] = 0; m_play[i] = 1'b0;
        end
        p_inst = 0; p_r = 1; p_c = 2; p_on = 1'b1;
        for (int k = 0; k < 20 * N && busy_a == 1'b0; k++) tick();
        p_on = 1'b0;
        repeat (3) tick();
        chk("mid_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_col", int'(col_a), 1);
        chk("mid_rst_led", int'(led_a), 7);
        chk("mid_rst_done", int'(done_a), 1);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_moves", int'(moves_a), 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_done", int'(done_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
